// File: rtl/dct_to_px_adapter.sv
// dct_to_px_adapter
//   Sits after the IDCT on the decode/loopback path. Each accepted parallel word
//   carries one 8-sample block row of signed IDCT output. The samples are shifted
//   back into the unsigned pixel range (+2^(PX_WIDTH-1)) with saturation, held in
//   a single row register and serialized, pixel 0 first, onto one of eight line
//   streams. Word k of a block goes to line k%8.
//
// Ports (AXI4-Stream bundles flattened to plain signals)
//   clk_i                 clock
//   rst_n_i               synchronous, active-low reset
//   par_video_tdata_i     8 signed samples, sample j in [j*IN_WIDTH +: IN_WIDTH]
//   par_video_tvalid_i    parallel word valid
//   par_video_tlast_i     parallel word tlast (stripe's last block)
//   par_video_tuser_i     parallel word tuser (frame start)
//   par_video_tready_o    parallel word ready
//   ser_video_tdata_o     per-line pixel, pixel in LSBs, upper bits zero
//   ser_video_tvalid_o    per-line valid (at most one line active)
//   ser_video_tlast_o     per-line tlast (last pixel of a tlast row)
//   ser_video_tuser_o     per-line tuser (first pixel of a tuser row)
//   ser_video_tready_i    per-line ready
module dct_to_px_adapter #(
  parameter int PX_WIDTH = 8,
  parameter int IN_WIDTH = PX_WIDTH + 3,
  localparam int SER_TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [8*IN_WIDTH-1:0]               par_video_tdata_i,
  input  logic                                par_video_tvalid_i,
  input  logic                                par_video_tlast_i,
  input  logic                                par_video_tuser_i,
  output logic                                par_video_tready_o,
  output logic [7:0][SER_TDATA_WIDTH-1:0]     ser_video_tdata_o,
  output logic [7:0]                          ser_video_tvalid_o,
  output logic [7:0]                          ser_video_tlast_o,
  output logic [7:0]                          ser_video_tuser_o,
  input  logic [7:0]                          ser_video_tready_i
);

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_e;

  // Offset back to unsigned and clamp. The sum is one bit wider than the input
  // so the most positive input plus the offset cannot wrap negative.
  function automatic logic [PX_WIDTH-1:0] sat_px(input logic signed [IN_WIDTH-1:0] s);
    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] off;
    logic signed [IN_WIDTH:0] maxv;
    off                  = '0;
    off[PX_WIDTH-1]      = 1'b1;
    maxv                 = '0;
    maxv[PX_WIDTH-1:0]   = '1;
    sum                  = {s[IN_WIDTH-1], s} + off;
    if (sum < 0)         return '0;
    else if (sum > maxv) return '1;
    else                 return sum[PX_WIDTH-1:0];
  endfunction

  state_e                     state_q, state_d;
  logic [7:0][PX_WIDTH-1:0]   row_q, row_d;
  logic                       row_tlast_q, row_tlast_d;
  logic                       row_tuser_q, row_tuser_d;
  logic [2:0]                 px_cnt_q, px_cnt_d;
  logic [2:0]                 ln_cnt_q, ln_cnt_d;

  logic                       last_px;
  logic                       emit;
  logic                       accept;
  logic [7:0][PX_WIDTH-1:0]   row_conv;

  assign last_px = (px_cnt_q == 3'd7);
  assign emit    = (state_q == SEND) && ser_video_tready_i[ln_cnt_q];

  // Ready also when the last pixel of the held row leaves this cycle, so the
  // next row loads without a bubble between lines.
  assign par_video_tready_o = rst_n_i && ((state_q == EMPTY) || (emit && last_px));
  assign accept             = par_video_tvalid_i && par_video_tready_o;

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      row_conv[j] = sat_px(par_video_tdata_i[j*IN_WIDTH +: IN_WIDTH]);
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_tlast_d = row_tlast_q;
    row_tuser_d = row_tuser_q;
    px_cnt_d    = px_cnt_q;
    ln_cnt_d    = ln_cnt_q;

    if (emit) begin
      if (last_px) begin
        px_cnt_d = 3'd0;
        ln_cnt_d = ln_cnt_q + 3'd1;
        state_d  = EMPTY;
      end else begin
        px_cnt_d = px_cnt_q + 3'd1;
      end
    end

    // A load overrides the drain-to-EMPTY above when both happen together.
    if (accept) begin
      row_d       = row_conv;
      row_tlast_d = par_video_tlast_i;
      row_tuser_d = par_video_tuser_i;
      px_cnt_d    = 3'd0;
      state_d     = SEND;
    end
  end

  // Control state: reset clears the row (EMPTY) and both counters.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= EMPTY;
      row_tlast_q <= 1'b0;
      row_tuser_q <= 1'b0;
      px_cnt_q    <= 3'd0;
      ln_cnt_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      row_tlast_q <= row_tlast_d;
      row_tuser_q <= row_tuser_d;
      px_cnt_q    <= px_cnt_d;
      ln_cnt_q    <= ln_cnt_d;
    end
  end

  // Pixel data: only meaningful while SEND, so it carries no reset.
  always_ff @(posedge clk_i) begin
    row_q <= row_d;
  end

  // Outputs are decoded purely from registers; idle lines read all zero.
  always_comb begin
    ser_video_tvalid_o = '0;
    ser_video_tdata_o  = '0;
    ser_video_tlast_o  = '0;
    ser_video_tuser_o  = '0;
    if (state_q == SEND) begin
      ser_video_tvalid_o[ln_cnt_q] = 1'b1;
      ser_video_tdata_o[ln_cnt_q]  = SER_TDATA_WIDTH'(row_q[px_cnt_q]);
      ser_video_tuser_o[ln_cnt_q]  = row_tuser_q && (px_cnt_q == 3'd0);
      ser_video_tlast_o[ln_cnt_q]  = row_tlast_q && last_px;
    end
  end

endmodule

// File: tb/tb_dct_to_px_adapter.sv
// Bench for dct_to_px_adapter: directed scenarios with randomized data and
// backpressure, checked against a pixel-order reference model.
module tb_dct_to_px_adapter;
  localparam int PX    = 8;
  localparam int IN_W  = PX + 3;
  localparam int SER_W = 8;

  typedef struct packed {
    logic               tu;
    logic               tl;
    logic [8*IN_W-1:0]  d;
  } word_t;

  typedef struct packed {
    logic [2:0] ln;
    logic       tu;
    logic       tl;
    logic [7:0] px;
  } pix_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [8*IN_W-1:0]        par_tdata;
  logic                     par_tvalid, par_tlast, par_tuser, par_tready;
  logic [7:0][SER_W-1:0]    ser_tdata;
  logic [7:0]               ser_tvalid, ser_tlast, ser_tuser, ser_tready;

  always #5 clk = ~clk;

  dct_to_px_adapter #(.PX_WIDTH(PX), .IN_WIDTH(IN_W)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .par_video_tdata_i  (par_tdata),
    .par_video_tvalid_i (par_tvalid),
    .par_video_tlast_i  (par_tlast),
    .par_video_tuser_i  (par_tuser),
    .par_video_tready_o (par_tready),
    .ser_video_tdata_o  (ser_tdata),
    .ser_video_tvalid_o (ser_tvalid),
    .ser_video_tlast_o  (ser_tlast),
    .ser_video_tuser_o  (ser_tuser),
    .ser_video_tready_i (ser_tready)
  );

  word_t src_q[$];
  pix_t  exp_q[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, emit_cnt = 0, acc_cnt = 0;
  int    first_emit = -1, last_emit = -1, first_acc = -1, last_acc = -1;
  int    model_ln = 0;
  int    gap_pct = 0;
  bit    rand_ready = 1'b0, check_spacing = 1'b0, acc_prev = 1'b0;
  bit    hold = 1'b0;
  int    hold_ln = 0;
  logic [SER_W-1:0] hold_data;
  logic  hold_tu, hold_tl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int conv(int s);
    int v = s + 2**(PX-1);
    if (v < 0) return 0;
    if (v > 2**PX - 1) return 2**PX - 1;
    return v;
  endfunction

  // Reference: every accepted word becomes 8 pixels on the next line in turn;
  // only one row is ever in flight, so pixels leave in global word order.
  task automatic model_accept(input word_t w);
    int s;
    pix_t p;
    for (int j = 0; j < 8; j++) begin
      s    = $signed(w.d[j*IN_W +: IN_W]);
      p.ln = 3'(model_ln);
      p.tu = w.tu && (j == 0);
      p.tl = w.tl && (j == 7);
      p.px = 8'(conv(s));
      exp_q.push_back(p);
    end
    model_ln = (model_ln + 1) % 8;
  endtask

  function automatic int rnd_sample();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 2047)) - 1024;
    return int'($urandom_range(0, 300)) - 150;
  endfunction

  task automatic add_word(input int s0, s1, s2, s3, s4, s5, s6, s7, input bit tu, tl);
    word_t w;
    w.d[0*IN_W +: IN_W] = IN_W'(s0); w.d[1*IN_W +: IN_W] = IN_W'(s1);
    w.d[2*IN_W +: IN_W] = IN_W'(s2); w.d[3*IN_W +: IN_W] = IN_W'(s3);
    w.d[4*IN_W +: IN_W] = IN_W'(s4); w.d[5*IN_W +: IN_W] = IN_W'(s5);
    w.d[6*IN_W +: IN_W] = IN_W'(s6); w.d[7*IN_W +: IN_W] = IN_W'(s7);
    w.tu = tu;
    w.tl = tl;
    src_q.push_back(w);
  endtask

  task automatic add_rand_word(input bit tu, tl);
    add_word(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(),
             rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), tu, tl);
  endtask

  task automatic step();
    int   nv, vl;
    word_t w;
    pix_t p;
    @(negedge clk);
    cyc++;
    nv = 0; vl = 0;
    for (int l = 0; l < 8; l++) if (ser_tvalid[l]) begin nv++; vl = l; end
    chk("valid_count", nv, (exp_q.size() > 0) ? 1 : 0);
    if (nv > 0 && exp_q.size() > 0) chk("line_index", vl, exp_q[0].ln);
    if (hold) begin
      chk("stable_valid", ser_tvalid[hold_ln], 1);
      chk("stable_data", ser_tdata[hold_ln], hold_data);
      chk("stable_flags", {ser_tuser[hold_ln], ser_tlast[hold_ln]}, {hold_tu, hold_tl});
    end
    if (acc_prev) begin par_tvalid = 1'b0; acc_prev = 1'b0; end
    if (!par_tvalid && src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      w          = src_q.pop_front();
      par_tvalid = 1'b1;
      par_tdata  = w.d;
      par_tlast  = w.tl;
      par_tuser  = w.tu;
    end
    ser_tready = rand_ready ? 8'($urandom) : 8'hFF;
    #1;
    hold = 1'b0;
    // Ready exactly when nothing is left, or the last remaining pixel goes now.
    chk("par_tready", par_tready,
        (exp_q.size() == 0 || (exp_q.size() == 1 && ser_tready[exp_q[0].ln])) ? 1 : 0);
    if (nv > 0 && exp_q.size() > 0) begin
      if (ser_tready[vl]) begin
        p = exp_q.pop_front();
        chk("pixel", ser_tdata[vl], p.px);
        chk("tuser", ser_tuser[vl], p.tu);
        chk("tlast", ser_tlast[vl], p.tl);
        emit_cnt++;
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
      end else begin
        hold      = 1'b1;
        hold_ln   = vl;
        hold_data = ser_tdata[vl];
        hold_tu   = ser_tuser[vl];
        hold_tl   = ser_tlast[vl];
      end
    end
    if (par_tvalid && par_tready) begin
      w.d = par_tdata; w.tl = par_tlast; w.tu = par_tuser;
      model_accept(w);
      acc_prev = 1'b1;
      if (acc_cnt == 0) first_acc = cyc;
      if (check_spacing && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 8);
      last_acc = cyc;
      acc_cnt++;
    end
  endtask

  task automatic new_test(input bit rr, input int gap, input bit sp);
    rand_ready = rr; gap_pct = gap; check_spacing = sp;
    emit_cnt = 0; acc_cnt = 0;
    first_emit = -1; last_emit = -1; first_acc = -1; last_acc = -1;
  endtask

  task automatic run_until(input int target, input int maxc);
    int c = 0;
    while (emit_cnt < target && c < maxc) begin step(); c++; end
    chk("progress", emit_cnt, target);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n      = 1'b0;
    par_tvalid = 1'b0;
    acc_prev   = 1'b0;
    hold       = 1'b0;
    ser_tready = 8'hFF;
    #1;
    chk("rst_tready", par_tready, 0);
    @(negedge clk);
    chk("rst_tvalid", ser_tvalid, 0);
    chk("rst_tlast", ser_tlast, 0);
    chk("rst_tuser", ser_tuser, 0);
    chk("rst_tdata_or", |ser_tdata, 0);
    rst_n = 1'b1;
    exp_q.delete();
    src_q.delete();
    model_ln = 0;
  endtask

  initial begin
    rst_n = 1'b0; par_tvalid = 1'b0; par_tdata = '0; par_tlast = 1'b0;
    par_tuser = 1'b0; ser_tready = 8'hFF;
    repeat (2) @(posedge clk);
    reset_dut();

    // Ramp block, full rate: line k emits 16k..16k+7, 64 pixels in 64 cycles.
    new_test(1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++)
      add_word(16*k-128, 16*k-127, 16*k-126, 16*k-125, 16*k-124, 16*k-123, 16*k-122, 16*k-121, 1'b0, 1'b0);
    run_until(64, 200);
    chk("latency", first_emit - first_acc, 1);
    chk("ramp_span", last_emit - first_emit + 1, 64);

    // Saturation row lands on line 0 after the full block.
    new_test(1'b0, 0, 1'b0);
    add_word(-300, -129, -128, 0, 127, 128, 200, 1023, 1'b0, 1'b0);
    run_until(8, 50);

    // Backpressure and flags: 4 random blocks, tuser on first word, tlast on last block.
    new_test(1'b1, 30, 1'b0);
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) add_rand_word(b == 0 && k == 0, b == 3);
    run_until(256, 5000);

    // Back-to-back, constant valid/ready: one accept per 8 cycles, no gaps.
    reset_dut();
    new_test(1'b0, 0, 1'b1);
    for (int k = 0; k < 16; k++) add_rand_word(1'b0, 1'b0);
    run_until(128, 400);
    chk("b2b_span", last_emit - first_emit + 1, 128);

    // Reset after 3 pixels of line 2; next word must start on line 0, pixel 0.
    new_test(1'b1, 0, 1'b0);
    for (int k = 0; k < 3; k++) add_rand_word(1'b0, 1'b0);
    run_until(19, 1000);
    reset_dut();
    new_test(1'b0, 0, 1'b0);
    add_word(-128, -127, 5, 6, 7, 8, 9, 10, 1'b1, 1'b0);
    run_until(8, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
